// File: rtl/change_disp_pkg.sv
// Shared types for the change dispenser: FSM state encoding, coin codes and
// the denomination value table indexed by coin code.
package change_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] COIN_1  = 3'd0;
  localparam logic [2:0] COIN_5  = 3'd1;
  localparam logic [2:0] COIN_10 = 3'd2;
  localparam logic [2:0] COIN_20 = 3'd3;
  localparam logic [2:0] COIN_50 = 3'd4;

  // Entry [code] is the face value in yuan of that coin code.
  localparam logic [4:0][7:0] DENOM_VALUE = {8'd50, 8'd20, 8'd10, 8'd5, 8'd1};

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    return (code <= COIN_50) ? DENOM_VALUE[code] : 8'd0;
  endfunction

endpackage

// File: rtl/change_dispenser_denom_select.sv
// Combinational greedy picker: largest denomination not exceeding the amount
// still owed (falls back to the 1-yuan coin).
module denom_select
  import change_disp_pkg::*;
(
  input  logic [7:0] remaining,
  output logic [2:0] coin_code
);

  always_comb begin
    // NOTE: every path assigns coin_code, so no latch is inferred.
    if (remaining >= DENOM_VALUE[COIN_50])      coin_code = COIN_50;
    else if (remaining >= DENOM_VALUE[COIN_20]) coin_code = COIN_20;
    else if (remaining >= DENOM_VALUE[COIN_10]) coin_code = COIN_10;
    else if (remaining >= DENOM_VALUE[COIN_5])  coin_code = COIN_5;
    else                                        coin_code = COIN_1;
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out change_money one coin at a time (greedy), with
// an enforced gap between coins. Define CHANGE_DISP_TALLY_EN for coin_tally.
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int GAP_W      = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] change_money,
  input  logic       abort,
  input  logic       coin_ready,
  output logic       coin_valid,
  output logic [2:0] coin_code,
  output logic [7:0] remaining_money,
  output logic       busy,
  output logic       done,
  output logic [4:0] coin_tally
);

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [2:0]         pick;
  logic [7:0]         rem_after;
  logic               handshake;

  denom_select u_denom_select (
    .remaining (remaining_money),
    .coin_code (pick)
  );

  assign handshake = coin_valid && coin_ready;
  // Greedy selection guarantees the coin value never exceeds what is owed.
  assign rem_after = remaining_money - coin_value(coin_code);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= S_IDLE;
      gap_cnt         <= '0;
      coin_valid      <= 1'b0;
      coin_code       <= COIN_1;
      remaining_money <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; the later done <= 1 in a branch wins.
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        state           <= S_IDLE;
        coin_valid      <= 1'b0;
        remaining_money <= 8'd0;
        busy            <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              remaining_money <= change_money;
              busy            <= 1'b1;
              if (change_money != 8'd0) begin
                state <= S_SELECT;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_SELECT: begin
            coin_code  <= pick;
            coin_valid <= 1'b1;
            state      <= S_ISSUE;
          end
          S_ISSUE: begin
            if (coin_ready) begin
              coin_valid      <= 1'b0;
              remaining_money <= rem_after;
              if (GAP_CYCLES > 0) begin
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                state   <= S_GAP;
              end else if (rem_after == 8'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_SELECT;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) begin
              if (remaining_money == 8'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_SELECT;
              end
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CHANGE_DISP_TALLY_EN
  // A coin handed over in the same cycle as abort is still counted.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      coin_tally <= 5'd0;
    end else if (state == S_IDLE && start && !abort) begin
      coin_tally <= 5'd0;
    end else if (handshake && coin_tally != 5'd31) begin
      coin_tally <= coin_tally + 5'd1;
    end
  end
`else
  assign coin_tally = 5'd0;
`endif

endmodule
